// File: rtl/estimador_matvec_mac3.sv
// Sequential Q-format 3x3 matrix * 3-vector multiply (y = M*x) through one shared multiplier.
// One MAC per cycle; each row is floored, saturated and stored before moving to the next.
module estimador_matvec_mac3 #(
    parameter int DATA_W = 32,
    parameter int FRAC_W = 16
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              ap_start,
    output logic              ap_done,
    output logic              ap_idle,
    output logic              ap_ready,
    input  logic [DATA_W-1:0] m_0_0,
    input  logic [DATA_W-1:0] m_0_1,
    input  logic [DATA_W-1:0] m_0_2,
    input  logic [DATA_W-1:0] m_1_0,
    input  logic [DATA_W-1:0] m_1_1,
    input  logic [DATA_W-1:0] m_1_2,
    input  logic [DATA_W-1:0] m_2_0,
    input  logic [DATA_W-1:0] m_2_1,
    input  logic [DATA_W-1:0] m_2_2,
    input  logic [DATA_W-1:0] x_0,
    input  logic [DATA_W-1:0] x_1,
    input  logic [DATA_W-1:0] x_2,
    output logic [DATA_W-1:0] y_0_out,
    output logic [DATA_W-1:0] y_1_out,
    output logic [DATA_W-1:0] y_2_out,
    output logic              y_0_out_ap_vld,
    output logic              y_1_out_ap_vld,
    output logic              y_2_out_ap_vld
);
    localparam int PROD_W = 2 * DATA_W;
    localparam int ACC_W  = 2 * DATA_W + 2;

    typedef enum logic [1:0] {IDLE, MAC, FIN, DONE} state_t;

    state_t                   state;
    logic [8:0][DATA_W-1:0]   m_r;
    logic [2:0][DATA_W-1:0]   x_r;
    logic [2:0][DATA_W-1:0]   y_r;
    logic [1:0]               row;
    logic [1:0]               col;
    logic signed [ACC_W-1:0]  acc;

    logic [3:0]               m_idx;
    logic signed [PROD_W-1:0] m_ext;
    logic signed [PROD_W-1:0] x_ext;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [ACC_W-1:0]  acc_shr;
    logic [ACC_W-DATA_W:0]    acc_hi;
    logic [DATA_W-1:0]        r_sat;

    assign m_idx   = 4'(row) * 4'd3 + 4'(col);
    assign m_ext   = PROD_W'($signed(m_r[m_idx]));
    assign x_ext   = PROD_W'($signed(x_r[col]));
    assign prod    = m_ext * x_ext;
    assign acc_sum = acc + ACC_W'(prod);
    assign acc_shr = acc >>> FRAC_W;
    // Result fits only if every bit above the DATA_W-1 sign bit matches it.
    assign acc_hi  = acc_shr[ACC_W-1:DATA_W-1];

    always_comb begin
        r_sat = acc_shr[DATA_W-1:0];
        if (acc_hi != '0 && acc_hi != '1)
            r_sat = acc_shr[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state          <= IDLE;
            m_r            <= '0;
            x_r            <= '0;
            y_r            <= '0;
            row            <= '0;
            col            <= '0;
            acc            <= '0;
            ap_done        <= 1'b0;
            ap_ready       <= 1'b0;
            ap_idle        <= 1'b1;
            y_0_out        <= '0;
            y_1_out        <= '0;
            y_2_out        <= '0;
            y_0_out_ap_vld <= 1'b0;
            y_1_out_ap_vld <= 1'b0;
            y_2_out_ap_vld <= 1'b0;
        end else begin
            ap_done        <= 1'b0;
            ap_ready       <= 1'b0;
            y_0_out_ap_vld <= 1'b0;
            y_1_out_ap_vld <= 1'b0;
            y_2_out_ap_vld <= 1'b0;
            case (state)
                IDLE: begin
                    if (ap_start) begin
                        m_r     <= {m_2_2, m_2_1, m_2_0, m_1_2, m_1_1, m_1_0, m_0_2, m_0_1, m_0_0};
                        x_r     <= {x_2, x_1, x_0};
                        row     <= '0;
                        col     <= '0;
                        acc     <= '0;
                        ap_idle <= 1'b0;
                        state   <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc_sum;
                    if (col == 2'd2) state <= FIN;
                    else             col   <= col + 2'd1;
                end
                FIN: begin
                    y_r[row] <= r_sat;
                    acc      <= '0;
                    if (row == 2'd2) begin
                        // Outputs and pulses are registered here so they appear in DONE.
                        y_0_out        <= y_r[0];
                        y_1_out        <= y_r[1];
                        y_2_out        <= r_sat;
                        ap_done        <= 1'b1;
                        ap_ready       <= 1'b1;
                        y_0_out_ap_vld <= 1'b1;
                        y_1_out_ap_vld <= 1'b1;
                        y_2_out_ap_vld <= 1'b1;
                        state          <= DONE;
                    end else begin
                        row   <= row + 2'd1;
                        col   <= '0;
                        state <= MAC;
                    end
                end
                DONE: begin
                    ap_idle <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_estimador_matvec_mac3.sv
// Scoreboard bench for estimador_matvec_mac3: stimulus pushes expected results and done cycle,
// a negedge monitor pops and compares whenever ap_done is seen.
module tb_estimador_matvec_mac3;
    localparam logic [31:0] Q1   = 32'h0001_0000;
    localparam logic [31:0] MAXV = 32'h7FFF_FFFF;
    localparam logic [31:0] MINV = 32'h8000_0000;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n, ap_start;
    logic        ap_done, ap_idle, ap_ready;
    logic [31:0] mv [9];
    logic [31:0] xv [3];
    logic [31:0] y_0_out, y_1_out, y_2_out;
    logic        y_0_out_ap_vld, y_1_out_ap_vld, y_2_out_ap_vld;

    typedef struct {
        logic [31:0] y0;
        logic [31:0] y1;
        logic [31:0] y2;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_total = 0;
    int   n_pass = 0;

    estimador_matvec_mac3 #(.DATA_W(32), .FRAC_W(16)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start),
        .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
        .m_0_0(mv[0]), .m_0_1(mv[1]), .m_0_2(mv[2]),
        .m_1_0(mv[3]), .m_1_1(mv[4]), .m_1_2(mv[5]),
        .m_2_0(mv[6]), .m_2_1(mv[7]), .m_2_2(mv[8]),
        .x_0(xv[0]), .x_1(xv[1]), .x_2(xv[2]),
        .y_0_out(y_0_out), .y_1_out(y_1_out), .y_2_out(y_2_out),
        .y_0_out_ap_vld(y_0_out_ap_vld), .y_1_out_ap_vld(y_1_out_ap_vld),
        .y_2_out_ap_vld(y_2_out_ap_vld)
    );

    always #5 ap_clk = ~ap_clk;
    always @(posedge ap_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every done must match the oldest pending expectation, at the predicted cycle.
    always @(negedge ap_clk) begin
        if (ap_rst_n === 1'b1) begin
            if (ap_done === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 64'(cyc), 64'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(e.cyc));
                    chk("y0", 64'(y_0_out), 64'(e.y0));
                    chk("y1", 64'(y_1_out), 64'(e.y1));
                    chk("y2", 64'(y_2_out), 64'(e.y2));
                    chk("vld_ready", {60'd0, y_0_out_ap_vld, y_1_out_ap_vld, y_2_out_ap_vld, ap_ready}, 64'hF);
                end
            end else if ((y_0_out_ap_vld | y_1_out_ap_vld | y_2_out_ap_vld | ap_ready) !== 1'b0) begin
                chk("stray_pulse", {60'd0, y_0_out_ap_vld, y_1_out_ap_vld, y_2_out_ap_vld, ap_ready}, 64'h0);
            end
        end
    end

    task automatic clr();
        for (int i = 0; i < 9; i++) mv[i] = '0;
        for (int i = 0; i < 3; i++) xv[i] = '0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge ap_clk);
        #1;
    endtask

    // Single-pulse start; caller is positioned just after a posedge with the DUT idle.
    task automatic go(input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
        sb.push_back('{e0, e1, e2, cyc + 13});
        ap_start = 1'b1;
        tick(1);
        ap_start = 1'b0;
        tick(15);
    endtask

    initial begin
        ap_rst_n = 1'b0;
        ap_start = 1'b0;
        clr();
        tick(2);
        @(negedge ap_clk);
        chk("rst_idle", 64'(ap_idle), 64'd1);
        chk("rst_done", 64'(ap_done), 64'd0);
        chk("rst_y", {ap_ready, y_0_out, y_1_out[30:0]}, 64'd0);
        tick(1);
        ap_rst_n = 1'b1;
        tick(1);

        // Identity
        clr(); mv[0] = Q1; mv[4] = Q1; mv[8] = Q1;
        xv[0] = 32'h0001_0000; xv[1] = 32'hFFFE_0000; xv[2] = 32'h0003_8000;
        go(32'h0001_0000, 32'hFFFE_0000, 32'h0003_8000);

        // Mixed matrix: rows [1 2 3],[0 -1 0],[0.5 0 0], x=(1,1,1)
        clr();
        mv[0] = 32'h0001_0000; mv[1] = 32'h0002_0000; mv[2] = 32'h0003_0000;
        mv[4] = 32'hFFFF_0000; mv[6] = 32'h0000_8000;
        xv[0] = Q1; xv[1] = Q1; xv[2] = Q1;
        go(32'h0006_0000, 32'hFFFF_0000, 32'h0000_8000);

        // Positive saturation
        for (int i = 0; i < 9; i++) mv[i] = MAXV;
        for (int i = 0; i < 3; i++) xv[i] = MAXV;
        go(MAXV, MAXV, MAXV);

        // Negative saturation on row 1 only
        clr(); mv[3] = MINV; mv[4] = MINV; mv[5] = MINV;
        for (int i = 0; i < 3; i++) xv[i] = MAXV;
        go(32'h0, MINV, 32'h0);

        // Floor toward -inf
        clr(); mv[0] = 32'h0000_0001; xv[0] = 32'h0000_8000;
        go(32'h0, 32'h0, 32'h0);
        mv[0] = 32'hFFFF_FFFF;
        go(32'hFFFF_FFFF, 32'h0, 32'h0);

        // Inputs changed mid-run and stray starts at cycles 3 and 10 are ignored
        clr(); mv[0] = 32'h0002_0000; mv[4] = 32'h0002_0000; mv[8] = 32'h0002_0000;
        xv[0] = 32'h0001_0000; xv[1] = 32'h0002_0000; xv[2] = 32'h0003_0000;
        sb.push_back('{32'h0002_0000, 32'h0004_0000, 32'h0006_0000, cyc + 13});
        ap_start = 1'b1;
        tick(1); ap_start = 1'b0;
        tick(2); ap_start = 1'b1;
        tick(1); ap_start = 1'b0;
        tick(1);
        for (int i = 0; i < 9; i++) mv[i] = 32'h1234_5678;
        for (int i = 0; i < 3; i++) xv[i] = 32'h1234_5678;
        tick(5); ap_start = 1'b1;
        tick(1); ap_start = 1'b0;
        tick(20);

        // Start held high: back-to-back runs, idle only on restart cycles
        clr(); mv[0] = Q1; mv[4] = Q1; mv[8] = Q1;
        xv[0] = 32'h0000_4000; xv[1] = 32'h0005_0000; xv[2] = 32'hFFFF_8000;
        for (int k = 0; k < 3; k++)
            sb.push_back('{32'h0000_4000, 32'h0005_0000, 32'hFFFF_8000, cyc + 13 + 14 * k});
        ap_start = 1'b1;
        for (int k = 0; k <= 44; k++) begin
            @(negedge ap_clk);
            chk($sformatf("held_idle_%0d", k), 64'(ap_idle),
                64'((k == 0 || k == 14 || k == 28 || k >= 42) ? 1 : 0));
            tick(1);
            if (k == 29) ap_start = 1'b0;
        end
        tick(4);

        // Reset at cycle 7 of a run discards it
        clr(); mv[0] = Q1; xv[0] = 32'h0007_0000;
        ap_start = 1'b1;
        tick(1); ap_start = 1'b0;
        tick(6);
        ap_rst_n = 1'b0;
        @(negedge ap_clk);
        chk("midrst_idle", 64'(ap_idle), 64'd1);
        chk("midrst_done", 64'(ap_done), 64'd0);
        chk("midrst_y", {y_0_out, y_1_out}, 64'd0);
        chk("midrst_y2", 64'(y_2_out), 64'd0);
        tick(1);
        ap_rst_n = 1'b1;
        tick(16);
        chk("post_rst_y", {y_0_out, y_2_out}, 64'd0);

        // Fresh run after reset
        clr(); mv[1] = 32'h0002_0000; mv[5] = Q1; mv[6] = 32'hFFFF_0000;
        xv[0] = 32'h0003_0000; xv[1] = 32'h0000_8000; xv[2] = 32'h0004_0000;
        go(32'h0001_0000, 32'h0004_0000, 32'hFFFD_0000);

        chk("pending_results", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
